// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for one frame.
//   Snoops the LBP engine's result writes (lbp_valid/lbp_data) and counts
//   each code into its bin. On lbp_finish the bins are drained in ascending
//   order over a valid/ready stream, then hist_done is held until reset.
// Ports:
//   clk, reset        - clock, async active-low reset
//   lbp_valid/_data   - one code per strobe from the LBP stage
//   lbp_finish        - end-of-frame level from the LBP stage
//   hist_valid/ready  - drain handshake
//   hist_bin/_count   - current beat: bin index and its count
//   pix_total         - codes accumulated this frame (saturating)
//   hist_done         - all 256 bins transferred

// One histogram bin: saturating up-counter.
module lbp_hist_bin #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module lbp_hist #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [7:0]       lbp_data,
  input  logic             lbp_finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [13:0]      pix_total,
  output logic             hist_done
);
  localparam int NUM_BINS = 256;

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_e;

  state_e                          state_q;
  logic                            hv_q, done_q;
  logic [7:0]                      bin_q;      // doubles as the drain pointer
  logic [CNT_W-1:0]                cnt_q;
  logic [13:0]                     pix_q;
  logic [7:0]                      bin_d;
  logic [NUM_BINS-1:0]             inc;
  logic [NUM_BINS-1:0][CNT_W-1:0]  bin_cnt;

  // Counters only move in ACCUM, so they are frozen for the whole drain.
  genvar b;
  generate
    for (b = 0; b < NUM_BINS; b++) begin : g_bin
      assign inc[b] = (state_q == ACCUM) && lbp_valid && (lbp_data == 8'(b));
      lbp_hist_bin #(.CNT_W(CNT_W)) u_bin (
        .clk   (clk),
        .reset (reset),
        .inc_i (inc[b]),
        .cnt_o (bin_cnt[b])
      );
    end
  endgenerate

  assign bin_d = bin_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      hv_q    <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (lbp_valid && pix_q != '1) pix_q <= pix_q + 14'd1;
          if (lbp_finish)               state_q <= DRAIN;
        end
        DRAIN: begin
          // First DRAIN cycle presents bin 0; the gap lets an increment
          // taken on the finish edge land in the array before it is read.
          if (!hv_q) begin
            hv_q  <= 1'b1;
            bin_q <= '0;
            cnt_q <= bin_cnt[0];
          end else if (hist_ready) begin
            if (bin_q == 8'hFF) begin
              hv_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              bin_q <= bin_d;
              cnt_q <= bin_cnt[bin_d];
            end
          end
        end
        DONE:    ;
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign hist_valid = hv_q;
  assign hist_bin   = bin_q;
  assign hist_count = cnt_q;
  assign pix_total  = pix_q;
  assign hist_done  = done_q;
endmodule

// File: tb/tb_lbp_hist.sv
module tb_lbp_hist;
  localparam int MAXC = 16383;
  localparam int MAXP = 16383;

  logic        clk = 1'b0;
  logic        reset, lbp_valid, lbp_finish, hist_ready;
  logic [7:0]  lbp_data, hist_bin;
  logic        hist_valid, hist_done;
  logic [13:0] hist_count, pix_total;

  // Narrow-counter instance for the bin saturation case.
  logic        s_valid, s_finish, s_ready, s_hv, s_done;
  logic [7:0]  s_data, s_bin;
  logic [3:0]  s_cnt;
  logic [13:0] s_pix;

  always #5 clk = ~clk;

  lbp_hist #(.CNT_W(14)) dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_data(lbp_data),
    .lbp_finish(lbp_finish), .hist_valid(hist_valid), .hist_ready(hist_ready),
    .hist_bin(hist_bin), .hist_count(hist_count), .pix_total(pix_total),
    .hist_done(hist_done)
  );

  lbp_hist #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .lbp_valid(s_valid), .lbp_data(s_data),
    .lbp_finish(s_finish), .hist_valid(s_hv), .hist_ready(s_ready),
    .hist_bin(s_bin), .hist_count(s_cnt), .pix_total(s_pix),
    .hist_done(s_done)
  );

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model and scoreboard.
  typedef struct { int bin; int cnt; } beat_t;
  beat_t expq[$];
  int    mbin[256];
  int    mpix;

  typedef struct { int frame; logic [7:0] code; int reps; int exp_pix; } vec_t;
  vec_t tbl[7];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; lbp_valid = 1'b0; lbp_finish = 1'b0; hist_ready = 1'b0; lbp_data = '0;
    s_valid = 1'b0; s_finish = 1'b0; s_ready = 1'b0; s_data = '0;
    foreach (mbin[i]) mbin[i] = 0;
    mpix = 0;
    expq.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic model_inc(input logic [7:0] code);
    if (mbin[code] < MAXC) mbin[code]++;
    if (mpix < MAXP) mpix++;
  endtask

  task automatic strobe(input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      lbp_valid = 1'b1; lbp_data = code; model_inc(code);
      @(negedge clk);
    end
    lbp_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit with_valid, input logic [7:0] code);
    lbp_finish = 1'b1;
    if (with_valid) begin lbp_valid = 1'b1; lbp_data = code; model_inc(code); end
    for (int b = 0; b < 256; b++) expq.push_back('{b, mbin[b]});
    @(negedge clk);
    lbp_finish = 1'b0; lbp_valid = 1'b0;
    chk("drain_gap_valid", hist_valid, 0);
  endtask

  // Drain with scoreboard; stop_at >= 0 leaves the loop when that bin is shown.
  task automatic drain(input bit rnd, input int stop_at, input bit junk, output int cycles);
    int beats = 0, hb = 0, hc = 0;
    bit holding = 0, stopped = 0, rdy;
    beat_t e;
    cycles = 0;
    while (beats < 256 && cycles < 3000) begin
      if (stop_at >= 0 && hist_valid && int'(hist_bin) == stop_at) begin stopped = 1; break; end
      chk("drain_done_low", hist_done, 0);
      if (holding) begin
        chk("hold_valid", hist_valid, 1);
        chk("hold_bin", hist_bin, hb);
        chk("hold_cnt", hist_count, hc);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hist_ready = rdy;
      if (junk) begin lbp_valid = 1'b1; lbp_data = 8'($urandom_range(0, 255)); end
      holding = 0;
      if (hist_valid) begin
        if (rdy) begin
          if (expq.size() == 0) chk("sb_empty", 1, 0);
          else begin
            e = expq.pop_front();
            chk("beat_bin", hist_bin, e.bin);
            chk("beat_cnt", hist_count, e.cnt);
          end
          beats++;
        end else begin
          holding = 1; hb = hist_bin; hc = hist_count;
        end
      end
      @(negedge clk);
      cycles++;
    end
    lbp_valid = 1'b0;
    if (!stopped) begin
      hist_ready = 1'b0;
      chk("drain_beats", beats, 256);
      chk("done_after", hist_done, 1);
      chk("valid_after", hist_valid, 0);
    end
  endtask

  initial begin
    int cyc;
    tbl[0] = '{0, 8'h00, 1, 1};
    tbl[1] = '{0, 8'hFF, 1, 2};
    tbl[2] = '{0, 8'h00, 1, 3};
    tbl[3] = '{1, 8'h10, 5, 5};
    tbl[4] = '{1, 8'h80, 7, 12};
    tbl[5] = '{1, 8'h10, 2, 14};
    tbl[6] = '{1, 8'hC3, 1, 15};

    reset = 1'b1; lbp_valid = 0; lbp_finish = 0; hist_ready = 0; lbp_data = 0;
    s_valid = 0; s_finish = 0; s_ready = 0; s_data = 0;

    // Async reset mid-cycle, checked before any edge.
    #12 reset = 1'b0;
    #1;
    chk("rst_valid", hist_valid, 0);
    chk("rst_bin", hist_bin, 0);
    chk("rst_cnt", hist_count, 0);
    chk("rst_pix", pix_total, 0);
    chk("rst_done", hist_done, 0);
    @(negedge clk); reset = 1'b1;
    foreach (mbin[i]) mbin[i] = 0;
    mpix = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_valid", hist_valid, 0);
      chk("idle_pix", pix_total, 0);
    end

    // Table-driven frames: frame 0 basic with ready=1, frame 1 backpressure.
    for (int f = 0; f < 2; f++) begin
      do_reset();
      for (int i = 0; i < 7; i++) begin
        if (tbl[i].frame == f) begin
          strobe(tbl[i].code, tbl[i].reps);
          chk("tbl_pix", pix_total, tbl[i].exp_pix);
        end
      end
      finish_frame(0, 8'h00);
      drain(f == 1, -1, 0, cyc);
      if (f == 0) chk("basic_cycles", cyc, 257);
      chk("frame_pix", pix_total, f == 0 ? 3 : 15);
    end

    // Same-cycle finish strobe, junk strobes in DRAIN, then DONE is sticky.
    do_reset();
    finish_frame(1, 8'h5A);
    drain(1, -1, 1, cyc);
    chk("same_pix", pix_total, 1);
    for (int i = 0; i < 5; i++) begin
      lbp_valid = 1'b1; lbp_finish = 1'b1; lbp_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("done_valid", hist_valid, 0);
      chk("done_hold", hist_done, 1);
      chk("done_pix", pix_total, 1);
    end
    lbp_valid = 1'b0; lbp_finish = 1'b0;

    // Bin saturation with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 8'h11;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("sat_pix", s_pix, 20);
    s_finish = 1'b1;
    @(negedge clk);
    s_finish = 1'b0; s_ready = 1'b1;
    cyc = 0;
    while (!s_hv && cyc < 10) begin @(negedge clk); cyc++; end
    chk("sat_start", s_hv, 1);
    if (s_hv) begin
      for (int i = 0; i < 256; i++) begin
        chk("sat_bin", s_bin, i);
        chk("sat_cnt", s_cnt, (i == 17) ? 15 : 0);
        @(negedge clk);
      end
      chk("sat_done", s_done, 1);
    end
    s_ready = 1'b0;

    // Full interior frame of 0xFF.
    do_reset();
    strobe(8'hFF, 15876);
    chk("full_pix", pix_total, 15876);
    finish_frame(0, 8'h00);
    drain(0, -1, 0, cyc);

    // Reset mid-drain, then a fresh frame.
    do_reset();
    strobe(8'h64, 3);
    strobe(8'h01, 1);
    finish_frame(0, 8'h00);
    drain(0, 100, 0, cyc);
    chk("mid_bin", hist_bin, 100);
    chk("mid_cnt", hist_count, 3);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", hist_valid, 0);
    chk("mid_rst_bin", hist_bin, 0);
    chk("mid_rst_cnt", hist_count, 0);
    chk("mid_rst_pix", pix_total, 0);
    chk("mid_rst_done", hist_done, 0);
    do_reset();
    strobe(8'h01, 1);
    finish_frame(0, 8'h00);
    drain(0, -1, 0, cyc);
    chk("new_pix", pix_total, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream consumer of the LBP stage's output stream. Snoops every `lbp_valid`/`lbp_data` write the LBP engine issues to the result memory and accumulates a 256-bin histogram of LBP codes for the 128x128 frame. When the LBP engine raises `finish`, the block drains the histogram bin by bin over a valid/ready stream for the feature/classifier stage, then holds `hist_done`.

## Interface
- `CNT_W`, 14, bin counter width; 14 covers the full 126x126 = 15876 interior pixels.
- `clk` input 1, sole clock; all logic on the rising edge.
- `reset` input 1, asynchronous, active-low; clears all state and outputs.
- `lbp_valid` input 1, one-cycle strobe from the LBP stage; one pixel code per strobe.
- `lbp_data` input 8, LBP code; sampled only when `lbp_valid`=1.
- `lbp_finish` input 1, level from the LBP stage's `finish`; marks end of frame.
- `hist_valid` output 1, a histogram beat is presented.
- `hist_ready` input 1, consumer accepts the beat.
- `hist_bin` output 8, bin index of the current beat.
- `hist_count` output CNT_W, count for `hist_bin`.
- `pix_total` output 14, number of codes accumulated this frame; saturates at 16383.
- `hist_done` output 1, all 256 bins transferred.

## Operation
- Storage: 256 x CNT_W counter array, plus an 8-bit drain pointer and a 2-bit state (ACCUM, DRAIN, DONE).
- ACCUM (reset state):
  - `lbp_valid`=1 increments `bin[lbp_data]` and `pix_total` by 1. Both saturate: a counter at its maximum holds.
  - `lbp_finish`=1 moves the block to DRAIN at the next edge. A `lbp_valid` in the same cycle as `lbp_finish` is still counted.
- DRAIN:
  - `lbp_valid` is ignored; counters are frozen.
  - A beat transfers on any edge where `hist_valid`=1 and `hist_ready`=1.
  - `hist_bin` and `hist_count` hold stable while `hist_valid`=1 and `hist_ready`=0.
  - Beats are issued in ascending order, bin 0 to bin 255, with no skips and no duplicates.
  - The transfer of bin 255 moves the block to DONE.
- DONE: `hist_valid`=0 and `hist_done`=1. The block stays in DONE until `reset`; `lbp_valid` and `lbp_finish` are ignored.
- Reset asserted in any state (including mid-drain):
  - The array, pointer and `pix_total` clear immediately.
  - State returns to ACCUM.
  - A partial drain is abandoned.

## Timing
- Reset values: `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `pix_total`=0, `hist_done`=0. All outputs are registered.
- Counter update: the count for a strobe sampled at edge E is visible in the array after E.
- Drain start: `lbp_finish` sampled at edge E puts the state in DRAIN after E. At edge E+1, `hist_valid` rises with `hist_bin`=0 and `hist_count`=`bin[0]`. This one-cycle gap lets the final same-cycle increment settle, so no bypass path is needed.
- Drain throughput: on a transfer at edge T, `hist_bin`/`hist_count` update to the next bin at T. With `hist_ready` held at 1, the drain produces one beat per cycle and 256 consecutive beats.
- Drain end: the transfer of bin 255 at edge T drives `hist_valid`=0 and `hist_done`=1 after T.
- Deassertion of `lbp_finish` during DRAIN or DONE has no effect.

## Test plan
- Reset/idle:
  - Stimulus: assert `reset`=0 mid-cycle.
  - Required: all outputs go to 0 without waiting for a clock edge.
  - Stimulus: release reset, then run 50 idle cycles.
  - Required: `hist_valid`=0 and `pix_total`=0 throughout.
- Basic frame:
  - Stimulus: strobe codes 0x00, 0xFF, 0x00, then `lbp_finish`=1, with `hist_ready`=1.
  - Required: exactly 256 beats. bin 0 = 2, bin 255 = 1, all other bins = 0. `pix_total`=3. `hist_done`=1 on the cycle after beat 255.
- Backpressure:
  - Stimulus: random `hist_ready` during the drain.
  - Required: `hist_bin`/`hist_count` stable whenever ready=0. Received bin sequence is exactly 0..255.
- Same-cycle end:
  - Stimulus: `lbp_valid`=1 with `lbp_data`=0x5A in the same cycle as `lbp_finish`=1.
  - Required: bin 0x5A = 1 and `pix_total`=1.
  - Stimulus: strobes during DRAIN.
  - Required: no count changes.
- Saturation:
  - Stimulus: CNT_W=4, 20 strobes of 0x11.
  - Required: bin 0x11 = 15 and `pix_total`=20.
  - Stimulus: full 15876-pixel frame of 0xFF with CNT_W=14.
  - Required: bin 255 = 15876.
- Reset mid-drain:
  - Stimulus: assert `reset` while `hist_bin`=100.
  - Required: outputs return to 0 and state returns to ACCUM.
  - Stimulus: a new frame with one strobe of 0x01, then finish.
  - Required: bin 1 = 1 and all other bins = 0.
